// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit geometry, flit type encoding and transmitter FSM states.
package noc_pkg;

    localparam int FLIT_WIDTH = 64;
    localparam int TYPE_MSB   = 63;
    localparam int TYPE_LSB   = 62;
    localparam int TYPE_WIDTH = TYPE_MSB - TYPE_LSB + 1;

    typedef enum logic [1:0] {
        BODY      = 2'b00,
        HEAD      = 2'b01,
        TAIL      = 2'b10,
        HEAD_TAIL = 2'b11
    } flit_type_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } tx_state_t;

    // True for the flit that closes a packet (TAIL or single-flit HEAD_TAIL).
    function automatic logic ends_packet(input flit_type_t t);
        return (t == TAIL) || (t == HEAD_TAIL);
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Small synchronous FIFO with first-word-fall-through read data and asynchronous reset.
module tx_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push, do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: storage is not reset; only pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/output_link_tx.sv
// Router output-port transmitter: framing check, flit queue and on/off-gated link driver.
module output_link_tx #(
    parameter int FLIT_WIDTH = noc_pkg::FLIT_WIDTH,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [FLIT_WIDTH-1:0] flit_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  on_off_i,
    output logic [FLIT_WIDTH-1:0] flit_o,
    output logic                  valid_o,
    output logic                  locked_o,
    output logic                  error_o,
    output logic [15:0]           pkt_count_o
);

    import noc_pkg::*;

    logic                  full, empty, accept, store, violation, pop;
    logic [FLIT_WIDTH-1:0] head_flit;
    flit_type_t            in_type, out_type;
    tx_state_t             state, next_state;

    assign ready_o  = !full;
    assign accept   = valid_i && ready_o;
    assign pop      = !empty && on_off_i;
    assign in_type  = flit_type_t'(flit_i[FLIT_WIDTH-1 -: TYPE_WIDTH]);
    assign out_type = flit_type_t'(head_flit[FLIT_WIDTH-1 -: TYPE_WIDTH]);
    assign locked_o = (state == ACTIVE) || !empty;

    tx_fifo #(
        .WIDTH (FLIT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (store),
        .wr_data (flit_i),
        .pop     (pop),
        .rd_data (head_flit),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        store      = 1'b0;
        violation  = 1'b0;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (in_type == HEAD) begin
                        store      = 1'b1;
                        next_state = ACTIVE;
                    end else if (in_type == HEAD_TAIL) begin
                        store = 1'b1;
                    end else begin
                        violation = 1'b1;
                    end
                end
                ACTIVE: begin
                    if (in_type == BODY) begin
                        store = 1'b1;
                    end else if (in_type == TAIL) begin
                        store      = 1'b1;
                        next_state = IDLE;
                    end else begin
                        violation = 1'b1;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Dropped flits are still handshaken; only the sticky error records them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flit_o      <= '0;
            valid_o     <= 1'b0;
            error_o     <= 1'b0;
            pkt_count_o <= '0;
        end else begin
            valid_o <= pop;
            if (pop) flit_o <= head_flit;
            if (pop && ends_packet(out_type)) pkt_count_o <= pkt_count_o + 16'd1;
            if (violation) error_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_output_link_tx.sv
// Directed self-checking bench for output_link_tx with hand-computed expectations.
module tb_output_link_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] flit_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic        on_off_i = 1'b0;
    logic [63:0] flit_o;
    logic        valid_o;
    logic        locked_o;
    logic        error_o;
    logic [15:0] pkt_count_o;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] H1 = 64'h4000_0000_0000_0001;
    localparam logic [63:0] B1 = 64'h0000_0000_0000_0002;
    localparam logic [63:0] T1 = 64'h8000_0000_0000_0003;
    localparam logic [63:0] H2 = 64'h4000_0000_0000_0010;
    localparam logic [63:0] B2 = 64'h0000_0000_0000_0011;
    localparam logic [63:0] T2 = 64'h8000_0000_0000_0012;
    localparam logic [63:0] HT = 64'hC000_0000_0000_0020;
    localparam logic [63:0] BX = 64'h0000_0000_0000_0030;
    localparam logic [63:0] H3 = 64'h4000_0000_0000_0040;
    localparam logic [63:0] H4 = 64'h4000_0000_0000_0041;
    localparam logic [63:0] T3 = 64'h8000_0000_0000_0042;
    localparam logic [63:0] H5 = 64'h4000_0000_0000_0050;
    localparam logic [63:0] B5 = 64'h0000_0000_0000_0051;
    localparam logic [63:0] H6 = 64'h4000_0000_0000_0060;

    output_link_tx #(
        .FLIT_WIDTH (64),
        .FIFO_DEPTH (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flit_i      (flit_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .on_off_i    (on_off_i),
        .flit_o      (flit_o),
        .valid_o     (valid_o),
        .locked_o    (locked_o),
        .error_o     (error_o),
        .pkt_count_o (pkt_count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #1 reset = 1'b1;
        tick();
        check("rst_ready", ready_o, 1);
        check("rst_valid", valid_o, 0);
        check("rst_flit", flit_o, 0);
        check("rst_locked", locked_o, 0);
        check("rst_error", error_o, 0);
        check("rst_count", pkt_count_o, 0);
        reset = 1'b0;

        // 3-flit packet, link open
        on_off_i = 1'b1; valid_i = 1'b1; flit_i = H1;
        tick();
        check("p1_e1_valid", valid_o, 0);
        check("p1_e1_locked", locked_o, 1);
        flit_i = B1;
        tick();
        check("p1_e2_flit", flit_o, H1);
        check("p1_e2_valid", valid_o, 1);
        check("p1_e2_locked", locked_o, 1);
        flit_i = T1;
        tick();
        check("p1_e3_flit", flit_o, B1);
        check("p1_e3_locked", locked_o, 1);
        valid_i = 1'b0;
        tick();
        check("p1_e4_flit", flit_o, T1);
        check("p1_e4_valid", valid_o, 1);
        check("p1_e4_count", pkt_count_o, 1);
        check("p1_e4_locked", locked_o, 0);
        tick();
        check("p1_e5_valid", valid_o, 0);
        check("p1_e5_hold", flit_o, T1);

        // Backpressure: link closed, FIFO fills after two accepts
        on_off_i = 1'b0; valid_i = 1'b1; flit_i = H2;
        tick();
        check("bp_acc1_ready", ready_o, 1);
        check("bp_acc1_valid", valid_o, 0);
        flit_i = B2;
        tick();
        check("bp_full_ready", ready_o, 0);
        check("bp_full_valid", valid_o, 0);
        flit_i = T2;
        tick();
        check("bp_stall_ready", ready_o, 0);
        check("bp_stall_valid", valid_o, 0);
        check("bp_stall_hold", flit_o, T1);
        on_off_i = 1'b1;
        tick();
        check("bp_drain1_flit", flit_o, H2);
        check("bp_drain1_valid", valid_o, 1);
        check("bp_drain1_ready", ready_o, 1);
        tick();
        check("bp_drain2_flit", flit_o, B2);
        check("bp_drain2_valid", valid_o, 1);
        valid_i = 1'b0;
        tick();
        check("bp_third_flit", flit_o, T2);
        check("bp_third_count", pkt_count_o, 2);
        check("bp_third_locked", locked_o, 0);

        // Single-flit packet
        valid_i = 1'b1; flit_i = HT;
        tick();
        check("ht_queued_locked", locked_o, 1);
        check("ht_queued_valid", valid_o, 0);
        valid_i = 1'b0;
        tick();
        check("ht_sent_flit", flit_o, HT);
        check("ht_sent_count", pkt_count_o, 3);
        check("ht_idle_locked", locked_o, 0);

        // Framing violations: BODY while idle, HEAD while active
        valid_i = 1'b1; flit_i = BX;
        tick();
        check("fv_body_error", error_o, 1);
        check("fv_body_locked", locked_o, 0);
        check("fv_body_ready", ready_o, 1);
        flit_i = H3;
        tick();
        check("fv_h3_locked", locked_o, 1);
        flit_i = H4;
        tick();
        check("fv_h3_sent", flit_o, H3);
        flit_i = T3;
        tick();
        check("fv_h4_dropped_valid", valid_o, 0);
        check("fv_h4_dropped_hold", flit_o, H3);
        valid_i = 1'b0;
        tick();
        check("fv_t3_sent", flit_o, T3);
        check("fv_t3_count", pkt_count_o, 4);
        check("fv_error_sticky", error_o, 1);

        // Packet counter wrap: stream HEAD_TAIL flits up to 0xFFFF, then one more
        valid_i = 1'b1; flit_i = HT;
        for (int i = 0; i < 65531; i++) tick();
        valid_i = 1'b0;
        tick();
        check("wrap_ffff", pkt_count_o, 16'hFFFF);
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        tick();
        check("wrap_zero", pkt_count_o, 16'h0000);
        check("wrap_error_sticky", error_o, 1);

        // Reset mid-packet with two flits queued
        on_off_i = 1'b0; valid_i = 1'b1; flit_i = H5;
        tick();
        flit_i = B5;
        tick();
        check("mid_full_ready", ready_o, 0);
        check("mid_locked", locked_o, 1);
        valid_i = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("mid_rst_ready", ready_o, 1);
        check("mid_rst_valid", valid_o, 0);
        check("mid_rst_flit", flit_o, 0);
        check("mid_rst_locked", locked_o, 0);
        check("mid_rst_error", error_o, 0);
        check("mid_rst_count", pkt_count_o, 0);
        #2 reset = 1'b0;
        on_off_i = 1'b1;
        tick();
        check("post_rst_flushed", valid_o, 0);
        valid_i = 1'b1; flit_i = H6;
        tick();
        check("post_rst_error", error_o, 0);
        check("post_rst_locked", locked_o, 1);
        valid_i = 1'b0;
        tick();
        check("post_rst_flit", flit_o, H6);
        check("post_rst_valid", valid_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/output_link_tx.md
# output_link_tx

Output-side transmitter of a wormhole NoC router port. It takes flits from the crossbar, holds them in a small FIFO and drives them onto the outgoing link only while the downstream input buffer signals room through its `on_off` flow-control line. It tracks packet framing so the switch allocator keeps the crossbar path locked from head flit to tail flit. It flags framing violations.

## Interface
- `FLIT_WIDTH`, 64, flit width in bits; type field is bits [63:62]
- `FIFO_DEPTH`, 2, internal flit slots; power of two, ≥2
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `flit_i`  in  FLIT_WIDTH  flit from crossbar
- `valid_i`  in  1  `flit_i` valid
- `ready_o`  out  1  FIFO can accept; transfer when `valid_i & ready_o`
- `on_off_i`  in  1  downstream buffer flow control; 1 = may send, 0 = stop
- `flit_o`  out  FLIT_WIDTH  flit on link
- `valid_o`  out  1  `flit_o` carries a flit this cycle
- `locked_o`  out  1  packet in progress; allocator holds grant
- `error_o`  out  1  sticky framing error
- `pkt_count_o`  out  16  tails/head-tails transmitted; wraps modulo 2^16

## Operation
- Flit type in [63:62]: 2'b01 HEAD, 2'b00 BODY, 2'b10 TAIL, 2'b11 HEAD_TAIL (single-flit packet).
- Write side:
  - `ready_o = !full`, with no same-cycle bypass.
  - With the FIFO full, `ready_o = 0` even if a pop occurs that cycle.
- Framing FSM, evaluated on accepted flits only:
  - IDLE: HEAD → ACTIVE, stored. HEAD_TAIL → stays IDLE, stored. BODY/TAIL → stays IDLE, flit dropped, `error_o` set.
  - ACTIVE: BODY → stays ACTIVE, stored. TAIL → IDLE, stored. HEAD/HEAD_TAIL → stays ACTIVE, dropped, `error_o` set.
  - A dropped flit is still handshaken, so `ready_o` behaves normally.
- Read side:
  - At each edge, if FIFO is non-empty and `on_off_i = 1`: pop the oldest flit, register it to `flit_o`, set `valid_o = 1`.
  - Otherwise `valid_o = 0` and `flit_o` holds its last value.
  - `on_off_i` is sampled at the edge, not registered.
- `pkt_count_o` increments by 1 on each edge that transmits TAIL or HEAD_TAIL. 0xFFFF wraps to 0x0000.
- `locked_o = (state == ACTIVE) || !empty` (combinational from registered state).
- `error_o` clears only on reset.

## Timing
- Reset values:
  - `ready_o` = 1 (FIFO empty)
  - `valid_o`, `flit_o`, `locked_o`, `error_o`, `pkt_count_o` = 0
  - FSM state = IDLE
- Latency: flit accepted at edge N appears on `flit_o` with `valid_o = 1` after edge N+1 at the earliest, provided `on_off_i = 1` at edge N+1.
- Throughput: one flit per cycle sustained while `on_off_i = 1`.
- Push and pop in the same edge are legal when not full; occupancy is unchanged.
- `on_off_i` falling at edge N: no flit is sent at edge N. The downstream buffer's `on_off` threshold absorbs link latency, so this block adds no slack of its own.
- Empty FIFO with `on_off_i = 1`: `valid_o = 0`.
- Reset asserted mid-packet: FIFO flushed, FSM to IDLE, all outputs to reset values immediately (asynchronous). The partial packet is lost.
- Pointers wrap modulo `FIFO_DEPTH`; occupancy counter is `$clog2(FIFO_DEPTH)+1` bits.

## Structure
- Shared package `noc_pkg`:
  - `FLIT_WIDTH`
  - type-field bit positions
  - `flit_type_t` enum {HEAD, BODY, TAIL, HEAD_TAIL}
  - `tx_state_t` enum {IDLE, ACTIVE}
- Sub-module `tx_fifo`: synchronous FIFO with `push`, `pop`, `full`, `empty` and asynchronous reset.
- Top level holds the framing FSM, the output register and the packet counter.

## Test plan
- Reset, then a 3-flit packet HEAD(0x4000…0001), BODY, TAIL with `on_off_i = 1` → flits on `flit_o` at edges 2, 3, 4 in order. `locked_o` is high from edge 1 until the cycle after the TAIL is sent. `pkt_count_o = 1`.
- Hold `on_off_i = 0` and push 3 flits → `ready_o` goes 0 after 2 accepts and `valid_o` stays 0. Raise `on_off_i` → both stored flits drain on consecutive edges, then the third is accepted.
- HEAD_TAIL flit in IDLE → transmitted, `locked_o` high only while it is queued, count +1. FSM stays IDLE.
- BODY in IDLE, then HEAD while ACTIVE → both dropped (never on `flit_o`). `error_o = 1` and stays 1 until reset.
- Preload `pkt_count_o` to 0xFFFF via 65535 HEAD_TAIL flits (or force), send one more HEAD_TAIL → `pkt_count_o = 0x0000`.
- Assert `reset` mid-packet with 2 flits queued → all outputs 0 and `ready_o = 1` in the same cycle. After release a new HEAD is accepted without error.
